// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud-rate helpers
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

    function automatic int tick_div(int clk_hz, int baud, int oversample);
        return clk_hz / (baud * oversample);
    endfunction

    function automatic int clk_per_bit(int clk_hz, int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign rd_ok   = rd_en && !empty;
    // a pop in the same cycle frees the slot being written
    assign wr_ok   = wr_en && (!full || rd_ok);

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART transceiver with oversampling RX, TX and an RX FIFO that can echo into TX
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 echo_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow
);
    localparam int DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CPB = clk_per_bit(CLK_HZ, BAUD);
    localparam int DW  = $clog2(DIV + 1);
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS);
    localparam parity_e PAR = PARITY == 1 ? PAR_ODD : PARITY == 2 ? PAR_EVEN : PAR_NONE;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_END    = OW'(OVERSAMPLE - 1);

    rx_state_e            rx_state, rx_next;
    logic                 rx_s1, rx_s2, rx_par, rx_push, rx_tick, rx_mid, par_bad;
    logic [DW-1:0]        div_cnt;
    logic [OW-1:0]        os_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 fifo_full, fifo_empty, fifo_rd;

    assign rx_tick  = div_cnt == DW'(DIV - 1);
    // first sample lands mid start bit, then one full bit apart
    assign rx_mid   = rx_tick && os_cnt == (rx_state == RX_START ? OS_MID : OS_END);
    assign par_bad  = PAR != PAR_NONE && ((^rx_shift ^ rx_par) != (PAR == PAR_ODD));
    assign rx_valid = !fifo_empty && !echo_en;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rx_s2) rx_next = RX_START;
            RX_START:  if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_mid && rx_bit == LAST_BIT) rx_next = PAR == PAR_NONE ? RX_STOP : RX_PARITY;
            RX_PARITY: if (rx_mid) rx_next = RX_STOP;
            RX_STOP:   if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rx_s2) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= RX_IDLE;
            div_cnt    <= '0;
            os_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par     <= 1'b0;
            rx_push    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_state   <= rx_next;
            rx_push    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (rx_state == RX_IDLE) begin
                div_cnt <= '0;
                os_cnt  <= '0;
                rx_bit  <= '0;
            end else begin
                div_cnt <= rx_tick ? '0 : div_cnt + 1'b1;
                if (rx_tick) os_cnt <= rx_mid ? '0 : os_cnt + 1'b1;
            end
            if (rx_mid && rx_state == RX_DATA) begin
                rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_mid && rx_state == RX_PARITY) rx_par <= rx_s2;
            if (rx_mid && rx_state == RX_STOP) begin
                frame_err  <= !rx_s2;
                parity_err <= par_bad;
                rx_push    <= rx_s2 && !par_bad;
            end
        end

    tx_state_e            tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift, tx_src;
    logic                 tx_par, tx_pop, tx_go, tx_end;

    assign tx_ready = tx_state == TX_IDLE && !echo_en;
    assign tx_pop   = tx_state == TX_IDLE && echo_en && !fifo_empty;
    assign tx_go    = tx_pop || (tx_ready && tx_valid);
    assign tx_src   = echo_en ? rx_data : tx_data;
    assign tx_end   = tx_cnt == CW'(CPB - 1);
    assign tx       = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] :
                      tx_state == TX_PARITY ? tx_par : 1'b1;
    assign fifo_rd  = tx_pop || (rx_valid && rx_ready);
    assign overflow = rx_push && fifo_full && !fifo_rd;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_go) tx_next = TX_START;
            TX_START:  if (tx_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_end && tx_bit == LAST_BIT) tx_next = PAR == PAR_NONE ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_end && tx_bit == LAST_STOP) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                if (tx_go) begin
                    tx_shift <= tx_src;
                    tx_par   <= ^tx_src ^ (PAR == PAR_ODD);
                end
            end else begin
                tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
                if (tx_end) begin
                    tx_bit <= tx_next != tx_state ? '0 : tx_bit + 1'b1;
                    if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
                end
            end
        end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (rx_shift),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (rx_data),
        .empty   (fifo_empty)
    );
endmodule
